// File: rtl/sys_array_lock_client.sv
`default_nettype none
// ============================================================================
// Module      : sys_array_lock_client
// Description : Per-thread initiator for the systolic-array two-lock protocol.
//               Queues tile jobs, acquires the load lock with the B address,
//               then the comp lock with the A/D/C addresses, and retires them.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_array_lock_client #(
    parameter int ADDRWIDTH = 16,
    parameter int JOBDEPTH  = 4,
    parameter int CTRWIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic                 job_skip_load,
    input  logic [ADDRWIDTH-1:0] job_b_addr,
    input  logic [ADDRWIDTH-1:0] job_a_addr,
    input  logic [ADDRWIDTH-1:0] job_d_addr,
    input  logic [ADDRWIDTH-1:0] job_c_addr,
    output logic                 load_lock_req,
    output logic [ADDRWIDTH-1:0] b_addr,
    input  logic                 load_lock_res,
    input  logic                 load_finished,
    output logic                 comp_lock_req,
    output logic [ADDRWIDTH-1:0] A_addr,
    output logic [ADDRWIDTH-1:0] D_addr,
    output logic [ADDRWIDTH-1:0] C_addr,
    input  logic                 comp_lock_res,
    input  logic                 comp_finished,
    output logic                 job_done,
    output logic [CTRWIDTH-1:0]  jobs_completed,
    output logic                 busy,
    output logic                 lock_error
);

    localparam int C_PTRW = $clog2(JOBDEPTH);
    localparam int C_CNTW = C_PTRW + 1;
    localparam int C_EW   = 4 * ADDRWIDTH + 1;
    localparam logic [C_CNTW-1:0] C_FULL = C_CNTW'(JOBDEPTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_REQ = 3'd1,
        S_LOAD_RUN = 3'd2,
        S_COMP_REQ = 3'd3,
        S_COMP_RUN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [C_EW-1:0]       fifo_q [JOBDEPTH];
    logic [C_PTRW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [C_CNTW-1:0]     count_q, count_d;
    logic                  ready_q;
    logic                  err_q, err_d;
    logic                  load_req_q, comp_req_q, done_q;
    logic [ADDRWIDTH-1:0]  b_q, a_q, d_q, c_q;
    logic [CTRWIDTH-1:0]   cnt_q;

    logic                  w_push, w_pop;
    logic [C_EW-1:0]       w_head;
    logic                  w_in_load, w_in_comp;

    // The head stays resident for the whole job; it is popped only on retire.
    assign w_push    = job_valid && ready_q;
    assign w_pop     = (state_q == S_DONE);
    assign w_head    = fifo_q[rd_ptr_q];
    assign count_d   = count_q + C_CNTW'(w_push) - C_CNTW'(w_pop);
    assign w_in_load = (state_d == S_LOAD_REQ) || (state_d == S_LOAD_RUN);
    assign w_in_comp = (state_d == S_COMP_REQ) || (state_d == S_COMP_RUN);

    // Job FIFO storage and pointers; contents are cleared by reset as well.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < JOBDEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= {job_skip_load, job_b_addr, job_a_addr,
                                     job_d_addr, job_c_addr};
                wr_ptr_q         <= wr_ptr_q + C_PTRW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + C_PTRW'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != C_FULL);
        end
    end

    // State register and the sticky protocol-violation flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; finished pulses are only honoured in the matching RUN state.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (load_lock_res && comp_lock_res) begin
            err_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d = w_head[C_EW-1] ? S_COMP_REQ : S_LOAD_REQ;
                end
            end
            S_LOAD_REQ: begin
                if (load_lock_res) state_d = S_LOAD_RUN;
            end
            S_LOAD_RUN: begin
                if (load_finished) begin
                    state_d = S_COMP_REQ;
                end else if (!load_lock_res) begin
                    err_d   = 1'b1;
                    state_d = S_COMP_REQ;
                end
            end
            S_COMP_REQ: begin
                if (comp_lock_res) state_d = S_COMP_RUN;
            end
            S_COMP_RUN: begin
                if (comp_finished) begin
                    state_d = S_DONE;
                end else if (!comp_lock_res) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the upcoming state, so requests drop on lock entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_req_q <= 1'b0;
            comp_req_q <= 1'b0;
            done_q     <= 1'b0;
            b_q        <= '0;
            a_q        <= '0;
            d_q        <= '0;
            c_q        <= '0;
            cnt_q      <= '0;
        end else begin
            load_req_q <= (state_d == S_LOAD_REQ);
            comp_req_q <= (state_d == S_COMP_REQ);
            done_q     <= (state_d == S_DONE);
            b_q        <= w_in_load ? w_head[4*ADDRWIDTH-1:3*ADDRWIDTH] : '0;
            a_q        <= w_in_comp ? w_head[3*ADDRWIDTH-1:2*ADDRWIDTH] : '0;
            d_q        <= w_in_comp ? w_head[2*ADDRWIDTH-1:ADDRWIDTH]   : '0;
            c_q        <= w_in_comp ? w_head[ADDRWIDTH-1:0]             : '0;
            if (state_d == S_DONE) begin
                cnt_q <= cnt_q + CTRWIDTH'(1);
            end
        end
    end

    assign job_ready      = ready_q;
    assign load_lock_req  = load_req_q;
    assign comp_lock_req  = comp_req_q;
    assign b_addr         = b_q;
    assign A_addr         = a_q;
    assign D_addr         = d_q;
    assign C_addr         = c_q;
    assign job_done       = done_q;
    assign jobs_completed = cnt_q;
    assign lock_error     = err_q;
    assign busy           = (state_q != S_IDLE) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_sys_array_lock_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_array_lock_client
// Description : Self-checking bench; the bench plays the lock controller and
//               keeps a queue of outstanding jobs as the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_array_lock_client;

    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          job_valid = 1'b0, job_skip_load = 1'b0;
    logic [AW-1:0] job_b_addr = '0, job_a_addr = '0, job_d_addr = '0, job_c_addr = '0;
    logic          load_lock_res = 1'b0, load_finished = 1'b0;
    logic          comp_lock_res = 1'b0, comp_finished = 1'b0;
    logic          job_ready, load_lock_req, comp_lock_req, job_done, busy, lock_error;
    logic [AW-1:0] b_addr, A_addr, D_addr, C_addr;
    logic [CW-1:0] jobs_completed;

    typedef struct {
        logic          skip;
        logic [AW-1:0] b, a, d, c;
    } job_t;

    job_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_done = 0;
    logic exp_err = 1'b0;

    sys_array_lock_client #(.ADDRWIDTH(AW), .JOBDEPTH(DEPTH), .CTRWIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_skip_load(job_skip_load),
        .job_b_addr(job_b_addr), .job_a_addr(job_a_addr),
        .job_d_addr(job_d_addr), .job_c_addr(job_c_addr),
        .load_lock_req(load_lock_req), .b_addr(b_addr),
        .load_lock_res(load_lock_res), .load_finished(load_finished),
        .comp_lock_req(comp_lock_req), .A_addr(A_addr), .D_addr(D_addr), .C_addr(C_addr),
        .comp_lock_res(comp_lock_res), .comp_finished(comp_finished),
        .job_done(job_done), .jobs_completed(jobs_completed),
        .busy(busy), .lock_error(lock_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic job_t rand_job();
        job_t j;
        j.skip = ($urandom_range(0, 3) == 0);
        j.b = AW'($urandom);
        j.a = AW'($urandom);
        j.d = AW'($urandom);
        j.c = AW'($urandom);
        return j;
    endfunction

    // Offer one job for one cycle; the model accepts it only if there is room.
    task automatic push(input job_t j);
        chk("job_ready", job_ready, (q.size() < DEPTH));
        if (q.size() < DEPTH) q.push_back(j);
        job_valid = 1'b1; job_skip_load = j.skip;
        job_b_addr = j.b; job_a_addr = j.a; job_d_addr = j.d; job_c_addr = j.c;
        @(negedge clock);
        job_valid = 1'b0;
    endtask

    // Act as the controller for the job at the head of the model queue.
    // mode: 0 normal, 1 stray load_finished in COMP_REQ, 2 load lock lost,
    //       3 both grants seen together, 4 stop right after comp grant.
    task automatic serve(input int gl, input int hl, input int gc, input int hc, input int mode);
        job_t j;
        j = q[0];
        if (!j.skip) begin
            for (int n = 0; n < 60 && load_lock_req !== 1'b1; n++) @(negedge clock);
            chk("load_req_rise", load_lock_req, 1);
            chk("comp_req_in_load", comp_lock_req, 0);
            for (int n = 0; n < gl; n++) begin
                chk("b_addr_req", b_addr, j.b);
                @(negedge clock);
            end
            chk("b_addr_req", b_addr, j.b);
            load_lock_res = 1'b1;
            @(negedge clock);
            chk("load_req_drop", load_lock_req, 0);
            chk("b_addr_run", b_addr, j.b);
            if (mode == 3) begin
                comp_lock_res = 1'b1; exp_err = 1'b1;
                @(negedge clock);
                comp_lock_res = 1'b0;
                chk("overlap_no_comp_req", comp_lock_req, 0);
                chk("overlap_err", lock_error, 1);
            end
            repeat (hl) @(negedge clock);
            if (mode == 2) begin
                load_lock_res = 1'b0; exp_err = 1'b1;
                @(negedge clock);
            end else begin
                load_finished = 1'b1;
                @(negedge clock);
                load_finished = 1'b0; load_lock_res = 1'b0;
            end
        end
        for (int n = 0; n < 60 && comp_lock_req !== 1'b1; n++) @(negedge clock);
        chk("comp_req_rise", comp_lock_req, 1);
        chk("load_req_off", load_lock_req, 0);
        chk("A_addr", A_addr, j.a);
        chk("D_addr", D_addr, j.d);
        chk("C_addr", C_addr, j.c);
        chk("lock_error_comp", lock_error, exp_err);
        if (mode == 1) begin
            load_finished = 1'b1;
            @(negedge clock);
            load_finished = 0;
            chk("stray_lf_req", comp_lock_req, 1);
            chk("stray_lf_err", lock_error, 0);
        end
        repeat (gc) @(negedge clock);
        chk("A_addr_hold", A_addr, j.a);
        comp_lock_res = 1'b1;
        @(negedge clock);
        chk("comp_req_drop", comp_lock_req, 0);
        chk("C_addr_run", C_addr, j.c);
        if (mode != 4) begin
            repeat (hc) @(negedge clock);
            comp_finished = 1'b1;
            @(negedge clock);
            comp_finished = 1'b0; comp_lock_res = 1'b0;
            exp_done++;
            chk("job_done", job_done, 1);
            chk("jobs_completed", jobs_completed, exp_done);
            chk("addr_zero_done", {A_addr, D_addr, C_addr, b_addr}, 0);
            @(negedge clock);
            chk("job_done_pulse", job_done, 0);
            void'(q.pop_front());
            chk("lock_error_end", lock_error, exp_err);
        end
    endtask

    initial begin
        job_t j;
        int   k;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_ready", job_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_reqs", {load_lock_req, comp_lock_req, job_done, lock_error}, 0);
        chk("rst_cnt", jobs_completed, 0);
        chk("rst_addr", {b_addr, A_addr, D_addr, C_addr}, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", job_ready, 1);

        // Single directed job
        j.skip = 1'b0; j.b = 16'h10; j.a = 16'h20; j.d = 16'h30; j.c = 16'h40;
        push(j);
        serve(3, 5, 2, 8, 0);
        chk("single_cnt", jobs_completed, 1);
        chk("single_idle_busy", busy, 0);

        // Skip-load job: comp request two cycles after the push cycle
        j = rand_job(); j.skip = 1'b1;
        push(j);
        chk("skip_req_early", comp_lock_req, 0);
        @(negedge clock);
        chk("skip_comp_req", comp_lock_req, 1);
        chk("skip_no_load_req", load_lock_req, 0);
        serve(1, 1, 1, 2, 0);

        // Stray load_finished during COMP_REQ
        j = rand_job(); j.skip = 1'b0;
        push(j);
        serve(1, 2, 2, 1, 1);

        // Both grants at once, then lost load lock (sticky error)
        j = rand_job(); j.skip = 1'b0;
        push(j);
        serve(0, 2, 1, 1, 3);
        j = rand_job(); j.skip = 1'b0;
        push(j);
        serve(2, 3, 0, 1, 2);
        chk("err_sticky", lock_error, 1);

        // Reset during COMP_RUN clears everything asynchronously
        j = rand_job(); j.skip = 1'b0;
        push(j);
        serve(1, 1, 1, 0, 4);
        chk("busy_before_rst", busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_reqs", {comp_lock_req, load_lock_req}, 0);
        chk("arst_cnt", jobs_completed, 0);
        chk("arst_err", lock_error, 0);
        q.delete(); exp_done = 0; exp_err = 1'b0; comp_lock_res = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", job_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Fill the FIFO with grants withheld; the fifth offer must be refused
        for (int i = 0; i < 5; i++) push(rand_job());
        chk("fill_ready_low", job_ready, 0);
        for (int i = 0; i < DEPTH; i++)
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 0);
        chk("fill_cnt", jobs_completed, 4);
        chk("fill_ready_back", job_ready, 1);

        // Randomized batches
        for (int r = 0; r < 5; r++) begin
            k = $urandom_range(1, DEPTH);
            for (int i = 0; i < k; i++) push(rand_job());
            while (q.size() != 0)
                serve($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), 0);
        end
        @(negedge clock);
        chk("final_busy", busy, 0);
        chk("final_cnt", jobs_completed, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
